// File: rtl/ulpb_resp_agent_if.sv
// Bundle of per-channel layer handshakes plus the shared event-log consumer port.
// The agent takes the slave side; the layer/host model takes the master side.
interface ulpb_resp_agent_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]            auto_rx_en;
    logic [NUM_CH-1:0]            rx_req;
    logic [NUM_CH-1:0]            rx_fail;
    logic [NUM_CH*ADDR_WIDTH-1:0] rx_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] rx_data;
    logic [NUM_CH-1:0]            rx_ack;
    logic [NUM_CH-1:0]            tx_succ;
    logic [NUM_CH-1:0]            tx_fail;
    logic [NUM_CH-1:0]            tx_resp_ack;
    logic                         log_valid;
    logic                         log_ready;
    logic [1:0]                   log_kind;
    logic [CH_W-1:0]              log_ch;
    logic [ADDR_WIDTH-1:0]        log_addr;
    logic [DATA_WIDTH-1:0]        log_data;
    logic [CNT_WIDTH-1:0]         ev_cnt;
    logic [CNT_WIDTH-1:0]         drop_cnt;

    modport slave (
        input  auto_rx_en, rx_req, rx_fail, rx_addr, rx_data, tx_succ, tx_fail, log_ready,
        output rx_ack, tx_resp_ack, log_valid, log_kind, log_ch, log_addr, log_data,
               ev_cnt, drop_cnt
    );

    modport master (
        output auto_rx_en, rx_req, rx_fail, rx_addr, rx_data, tx_succ, tx_fail, log_ready,
        input  rx_ack, tx_resp_ack, log_valid, log_kind, log_ch, log_addr, log_data,
               ev_cnt, drop_cnt
    );
endinterface

// File: rtl/ulpb_resp_agent.sv
// N-channel handshake closer: per-channel RX/TX ack FSMs, round-robin grant,
// and a shared show-ahead event log FIFO with saturating event/drop counters.
//
//   state  | meaning
//   R_IDLE | RX source waiting for a grant; rx_ack low
//   R_ACK  | RX event taken; rx_ack high until rx_req and rx_fail both drop
//   T_IDLE | TX source waiting for a grant; tx_resp_ack low
//   T_ACK  | TX event taken; tx_resp_ack high until tx_succ and tx_fail both drop
module ulpb_resp_agent #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int DROP_ON_FULL = 0
) (
    input logic            clk,
    input logic            resetn,
    ulpb_resp_agent_if.slave bus
);
    localparam int NREQ  = 2 * NUM_CH;
    localparam int PTR_W = $clog2(NREQ);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = 2 + CH_W + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [AW:0]          FPTR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    typedef enum logic {R_IDLE, R_ACK} rx_state_e;
    typedef enum logic {T_IDLE, T_ACK} tx_state_e;

    rx_state_e rx_state_q [NUM_CH];
    rx_state_e rx_state_d [NUM_CH];
    tx_state_e tx_state_q [NUM_CH];
    tx_state_e tx_state_d [NUM_CH];

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       gnt;
    logic                  gnt_vld;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]            ent_kind;
    logic [CH_W-1:0]       ent_ch;
    logic [ADDR_WIDTH-1:0] ent_addr;
    logic [DATA_WIDTH-1:0] ent_data;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [EW-1:0]         head;
    logic [AW:0]           wptr_q, rptr_q;
    logic                  full, empty, push, pop, drop;
    logic [CNT_WIDTH-1:0]  ev_cnt_q, drop_cnt_q;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = gnt_vld && !full;
    assign drop  = gnt_vld && full;
    assign pop   = !empty && bus.log_ready;

    // Even requester indices are RX, odd are TX, so requester 2*ch+1 sits next to its RX twin.
    always_comb begin
        req = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            req[2*ch]   = (rx_state_q[ch] == R_IDLE) &&
                          (bus.rx_fail[ch] || (bus.rx_req[ch] && bus.auto_rx_en[ch]));
            req[2*ch+1] = (tx_state_q[ch] == T_IDLE) && (bus.tx_succ[ch] || bus.tx_fail[ch]);
        end
    end

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        rr_ptr_d = rr_ptr_q;
        if ((DROP_ON_FULL != 0) || !full) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!gnt_vld && req[(int'(rr_ptr_q) + k) % NREQ]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
                end
            end
        end
        gnt = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
        if (gnt_vld) begin
            rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_comb begin
        ent_ch   = CH_W'(int'(gnt_idx) / 2);
        ent_kind = 2'd0;
        ent_addr = '0;
        ent_data = '0;
        if (!gnt_idx[0]) begin
            if (bus.rx_fail[ent_ch]) begin
                ent_kind = 2'd1;
            end else begin
                ent_addr = bus.rx_addr[ent_ch*ADDR_WIDTH +: ADDR_WIDTH];
                ent_data = bus.rx_data[ent_ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            ent_kind = bus.tx_succ[ent_ch] ? 2'd2 : 2'd3;
        end
    end

    always_comb begin
        bus.rx_ack      = '0;
        bus.tx_resp_ack = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rx_state_d[ch] = rx_state_q[ch];
            tx_state_d[ch] = tx_state_q[ch];
            case (rx_state_q[ch])
                R_IDLE: if (gnt[2*ch]) rx_state_d[ch] = R_ACK;
                R_ACK: begin
                    bus.rx_ack[ch] = 1'b1;
                    if (!(bus.rx_req[ch] || bus.rx_fail[ch])) rx_state_d[ch] = R_IDLE;
                end
            endcase
            case (tx_state_q[ch])
                T_IDLE: if (gnt[2*ch+1]) tx_state_d[ch] = T_ACK;
                T_ACK: begin
                    bus.tx_resp_ack[ch] = 1'b1;
                    if (!(bus.tx_succ[ch] || bus.tx_fail[ch])) tx_state_d[ch] = T_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rx_state_q[ch] <= R_IDLE;
                tx_state_q[ch] <= T_IDLE;
            end
            rr_ptr_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ev_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rx_state_q[ch] <= rx_state_d[ch];
                tx_state_q[ch] <= tx_state_d[ch];
            end
            rr_ptr_q <= rr_ptr_d;
            if (push) wptr_q <= wptr_q + FPTR_ONE;
            if (pop)  rptr_q <= rptr_q + FPTR_ONE;
            if (push && (ev_cnt_q != '1))   ev_cnt_q   <= ev_cnt_q + CNT_ONE;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_ONE;
        end
    end

    // Storage needs no reset: nothing is visible until the write pointer moves past it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= {ent_kind, ent_ch, ent_addr, ent_data};
    end

    assign head          = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign bus.log_valid = !empty;
    assign {bus.log_kind, bus.log_ch, bus.log_addr, bus.log_data} = head;
    assign bus.ev_cnt    = ev_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_ulpb_resp_agent.sv
// Directed handshake/arbitration/FIFO-policy scenarios on a stall-mode and a drop-mode
// agent, followed by a randomized multi-channel run against an event-list model.
module tb_ulpb_resp_agent;
    localparam int NUM_CH = 4;
    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int FD     = 4;
    localparam int CW     = 16;
    localparam int NSRC   = 2 * NUM_CH;

    typedef struct packed {
        logic [2:0]    src;
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ulpb_resp_agent_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) ifs ();
    ulpb_resp_agent_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) ifd ();

    ulpb_resp_agent #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD),
                      .CNT_WIDTH(CW), .DROP_ON_FULL(0))
        u_stall (.clk(clk), .resetn(resetn), .bus(ifs.slave));

    ulpb_resp_agent #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD),
                      .CNT_WIDTH(CW), .DROP_ON_FULL(1))
        u_drop (.clk(clk), .resetn(resetn), .bus(ifd.slave));

    int total = 0;
    int bad   = 0;

    int            phase [NSRC];
    int            wt    [NSRC];
    logic [1:0]    ckind [NSRC];
    logic [AW-1:0] caddr [NSRC];
    logic [DW-1:0] cdata [NSRC];
    ev_t           expq [$];
    int            nexp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifs.auto_rx_en = '0; ifs.rx_req = '0; ifs.rx_fail = '0; ifs.rx_addr = '0;
        ifs.rx_data = '0; ifs.tx_succ = '0; ifs.tx_fail = '0; ifs.log_ready = 1'b0;
        ifd.auto_rx_en = '0; ifd.rx_req = '0; ifd.rx_fail = '0; ifd.rx_addr = '0;
        ifd.rx_data = '0; ifd.tx_succ = '0; ifd.tx_fail = '0; ifd.log_ready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        cyc(1);
    endtask

    task automatic chk_head(input string tag, input bit use_drop, input logic [1:0] k,
                            input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic v; logic [1:0] hk; logic [1:0] hc; logic [AW-1:0] ha; logic [DW-1:0] hd;
        if (use_drop) begin
            v = ifd.log_valid; hk = ifd.log_kind; hc = ifd.log_ch; ha = ifd.log_addr; hd = ifd.log_data;
        end else begin
            v = ifs.log_valid; hk = ifs.log_kind; hc = ifs.log_ch; ha = ifs.log_addr; hd = ifs.log_data;
        end
        chk({tag, "_valid"}, v, 1);
        chk({tag, "_kind"}, hk, k);
        chk({tag, "_ch"}, hc, 64'(ch));
        chk({tag, "_addr"}, ha, a);
        chk({tag, "_data"}, hd, d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        clear_inputs();
        resetn = 1'b0;
        cyc(2);
        chk("rst_rx_ack", ifs.rx_ack, 0);
        chk("rst_tx_resp_ack", ifs.tx_resp_ack, 0);
        chk("rst_log_valid", ifs.log_valid, 0);
        chk("rst_ev_cnt", ifs.ev_cnt, 0);
        chk("rst_drop_cnt", ifs.drop_cnt, 0);
        resetn = 1'b1;
        cyc(1);

        // single RX on ch1
        ifs.auto_rx_en = 4'b0010;
        ifs.rx_addr[8 +: 8]   = 8'hab;
        ifs.rx_data[32 +: 32] = 32'hdeadbeef;
        ifs.rx_req[1] = 1'b1;
        chk("t1_ack_before", ifs.rx_ack[1], 0);
        cyc(1);
        chk("t1_ack_rise", ifs.rx_ack[1], 1);
        chk_head("t1_head", 0, 2'd0, 1, 8'hab, 32'hdeadbeef);
        chk("t1_ev_cnt", ifs.ev_cnt, 1);
        ifs.rx_req[1] = 1'b0;
        cyc(1);
        chk("t1_ack_fall", ifs.rx_ack[1], 0);
        ifs.log_ready = 1'b1;
        cyc(1);
        ifs.log_ready = 1'b0;
        chk("t1_popped", ifs.log_valid, 0);

        // auto-ack disabled, then RX_FAIL is still served
        ifs.auto_rx_en = 4'b0000;
        ifs.rx_addr[16 +: 8]  = 8'h55;
        ifs.rx_data[64 +: 32] = 32'h12345678;
        ifs.rx_req[2] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            cyc(1);
            if (ifs.rx_ack[2]) seen = 1'b1;
        end
        chk("t2_no_ack", seen, 0);
        chk("t2_no_log", ifs.log_valid, 0);
        chk("t2_ev_cnt_hold", ifs.ev_cnt, 1);
        ifs.rx_fail[2] = 1'b1;
        cyc(1);
        chk("t2_fail_ack", ifs.rx_ack[2], 1);
        chk_head("t2_head", 0, 2'd1, 2, 8'h00, 32'h0);
        chk("t2_ev_cnt", ifs.ev_cnt, 2);
        ifs.rx_req[2] = 1'b0;
        ifs.rx_fail[2] = 1'b0;
        cyc(1);
        chk("t2_ack_fall", ifs.rx_ack[2], 0);
        ifs.log_ready = 1'b1;
        cyc(1);
        ifs.log_ready = 1'b0;

        // simultaneous events from round-robin pointer 0
        do_reset();
        ifs.auto_rx_en = 4'hf;
        ifs.rx_addr[8 +: 8]   = 8'h3c;
        ifs.rx_data[32 +: 32] = 32'hcafef00d;
        ifs.tx_succ[0] = 1'b1;
        ifs.tx_fail[3] = 1'b1;
        ifs.rx_req[1]  = 1'b1;
        cyc(1);
        chk("t3_c1_tx0", ifs.tx_resp_ack[0], 1);
        chk("t3_c1_rx1", ifs.rx_ack[1], 0);
        chk("t3_c1_tx3", ifs.tx_resp_ack[3], 0);
        cyc(1);
        chk("t3_c2_rx1", ifs.rx_ack[1], 1);
        chk("t3_c2_tx3", ifs.tx_resp_ack[3], 0);
        cyc(1);
        chk("t3_c3_tx3", ifs.tx_resp_ack[3], 1);
        chk("t3_ev_cnt", ifs.ev_cnt, 3);
        ifs.tx_succ[0] = 1'b0;
        ifs.tx_fail[3] = 1'b0;
        ifs.rx_req[1]  = 1'b0;
        cyc(2);
        chk("t3_rx_ack_low", ifs.rx_ack, 0);
        chk("t3_tx_ack_low", ifs.tx_resp_ack, 0);
        chk_head("t3_e0", 0, 2'd2, 0, 8'h00, 32'h0);
        ifs.log_ready = 1'b1;
        cyc(1);
        chk_head("t3_e1", 0, 2'd0, 1, 8'h3c, 32'hcafef00d);
        cyc(1);
        chk_head("t3_e2", 0, 2'd3, 3, 8'h00, 32'h0);
        cyc(1);
        ifs.log_ready = 1'b0;
        chk("t3_empty", ifs.log_valid, 0);

        // stall policy: fifth event waits for a pop
        do_reset();
        ifs.auto_rx_en = 4'h1;
        for (int e = 0; e < 4; e++) begin
            ifs.rx_addr[0 +: 8]  = 8'h10 + 8'(e);
            ifs.rx_data[0 +: 32] = 32'h1000_0000 + 32'(e);
            ifs.rx_req[0] = 1'b1;
            cyc(1);
            chk("t4_ack", ifs.rx_ack[0], 1);
            ifs.rx_req[0] = 1'b0;
            cyc(1);
            chk("t4_ack_fall", ifs.rx_ack[0], 0);
        end
        chk("t4_ev_cnt4", ifs.ev_cnt, 4);
        ifs.rx_addr[0 +: 8]  = 8'h14;
        ifs.rx_data[0 +: 32] = 32'h1000_0004;
        ifs.rx_req[0] = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            cyc(1);
            if (ifs.rx_ack[0]) seen = 1'b1;
        end
        chk("t4_stalled", seen, 0);
        ifs.log_ready = 1'b1;
        cyc(1);
        ifs.log_ready = 1'b0;
        chk("t4_no_ack_pop_cycle", ifs.rx_ack[0], 0);
        chk("t4_ev_cnt_pop_cycle", ifs.ev_cnt, 4);
        cyc(1);
        chk("t4_ack_after_pop", ifs.rx_ack[0], 1);
        chk("t4_ev_cnt5", ifs.ev_cnt, 5);
        chk("t4_drop_cnt", ifs.drop_cnt, 0);
        ifs.rx_req[0] = 1'b0;
        cyc(1);
        ifs.log_ready = 1'b1;
        for (int e = 1; e < 5; e++) begin
            chk_head("t4_pop", 0, 2'd0, 0, 8'h10 + 8'(e), 32'h1000_0000 + 32'(e));
            cyc(1);
        end
        ifs.log_ready = 1'b0;
        chk("t4_empty", ifs.log_valid, 0);

        // drop policy on the second agent
        ifd.auto_rx_en = 4'h1;
        for (int e = 0; e < 5; e++) begin
            ifd.rx_addr[0 +: 8]  = 8'h20 + 8'(e);
            ifd.rx_data[0 +: 32] = 32'h2000_0000 + 32'(e);
            ifd.rx_req[0] = 1'b1;
            cyc(1);
            chk("t5_ack", ifd.rx_ack[0], 1);
            ifd.rx_req[0] = 1'b0;
            cyc(1);
        end
        chk("t5_drop_cnt", ifd.drop_cnt, 1);
        chk("t5_ev_cnt", ifd.ev_cnt, 4);
        ifd.log_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            chk_head("t5_pop", 1, 2'd0, 0, 8'h20 + 8'(e), 32'h2000_0000 + 32'(e));
            cyc(1);
        end
        ifd.log_ready = 1'b0;
        chk("t5_empty", ifd.log_valid, 0);

        // reset in the middle of a handshake
        do_reset();
        ifs.auto_rx_en = 4'h1;
        ifs.rx_addr[0 +: 8]  = 8'h77;
        ifs.rx_data[0 +: 32] = 32'ha5a5a5a5;
        ifs.rx_req[0] = 1'b1;
        cyc(1);
        chk("t6_ack_pre", ifs.rx_ack[0], 1);
        chk("t6_ev_cnt_pre", ifs.ev_cnt, 1);
        resetn = 1'b0;
        #1;
        chk("t6_rst_ack", ifs.rx_ack, 0);
        chk("t6_rst_valid", ifs.log_valid, 0);
        chk("t6_rst_ev_cnt", ifs.ev_cnt, 0);
        chk("t6_rst_drop_cnt", ifs.drop_cnt, 0);
        @(negedge clk);
        resetn = 1'b1;
        cyc(1);
        chk("t6_reack", ifs.rx_ack[0], 1);
        chk_head("t6_relog", 0, 2'd0, 0, 8'h77, 32'ha5a5a5a5);
        chk("t6_ev_cnt", ifs.ev_cnt, 1);
        ifs.rx_req[0] = 1'b0;
        ifs.log_ready = 1'b1;
        cyc(1);
        ifs.log_ready = 1'b0;

        // randomized traffic on all sources against an event-list model
        clear_inputs();
        do_reset();
        ifs.auto_rx_en = 4'hf;
        nexp = 0;
        for (int s = 0; s < NSRC; s++) begin
            phase[s] = 0;
            wt[s] = 0;
        end
        for (int c = 0; c < 3500; c++) begin
            bit rdy;
            @(negedge clk);
            for (int s = 0; s < NSRC; s++) begin
                int ch;
                int r;
                bit tx;
                bit ack;
                ch  = s / 2;
                tx  = (s % 2) == 1;
                ack = tx ? ifs.tx_resp_ack[ch] : ifs.rx_ack[ch];
                case (phase[s])
                    0: if (c < 3000 && $urandom_range(0, 3) == 0) begin
                        r = int'($urandom_range(0, 3));
                        caddr[s] = 8'($urandom);
                        cdata[s] = $urandom;
                        if (!tx) begin
                            ifs.rx_addr[ch*AW +: AW] = caddr[s];
                            ifs.rx_data[ch*DW +: DW] = cdata[s];
                            ifs.rx_fail[ch] = (r <= 1);
                            ifs.rx_req[ch]  = (r >= 1);
                            ckind[s] = (r <= 1) ? 2'd1 : 2'd0;
                        end else begin
                            ifs.tx_fail[ch] = (r <= 1);
                            ifs.tx_succ[ch] = (r >= 1);
                            ckind[s] = (r >= 1) ? 2'd2 : 2'd3;
                        end
                        phase[s] = 1;
                        wt[s] = 0;
                    end
                    1: begin
                        if (ack) begin
                            expq.push_back('{src: 3'(s), kind: ckind[s],
                                             addr: (ckind[s] == 2'd0) ? caddr[s] : '0,
                                             data: (ckind[s] == 2'd0) ? cdata[s] : '0});
                            nexp++;
                            phase[s] = 2;
                        end else begin
                            wt[s]++;
                            total++;
                            assert (wt[s] < 300) else begin
                                bad++;
                                $error("FAIL rnd_ack_wait src=%0d observed=%0d expected<300", s, wt[s]);
                                phase[s] = 2;
                            end
                        end
                        if (phase[s] == 2) begin
                            if (tx) begin
                                ifs.tx_succ[ch] = 1'b0;
                                ifs.tx_fail[ch] = 1'b0;
                            end else begin
                                ifs.rx_req[ch]  = 1'b0;
                                ifs.rx_fail[ch] = 1'b0;
                            end
                        end
                    end
                    default: if (!ack) phase[s] = 0;
                endcase
            end
            rdy = (c >= 3000) || ($urandom_range(0, 1) == 1);
            ifs.log_ready = rdy;
            if (rdy && ifs.log_valid) begin
                int src;
                int fi;
                src = int'(ifs.log_ch) * 2 + ((ifs.log_kind >= 2'd2) ? 1 : 0);
                fi = -1;
                for (int i = 0; i < expq.size(); i++) begin
                    if (fi < 0 && int'(expq[i].src) == src) fi = i;
                end
                chk("rnd_found", (fi >= 0), 1);
                if (fi >= 0) begin
                    chk("rnd_entry", {ifs.log_kind, ifs.log_addr, ifs.log_data},
                        {expq[fi].kind, expq[fi].addr, expq[fi].data});
                    expq.delete(fi);
                end
            end
        end
        ifs.log_ready = 1'b0;
        cyc(1);
        chk("rnd_model_empty", expq.size(), 0);
        chk("rnd_fifo_empty", ifs.log_valid, 0);
        chk("rnd_ev_cnt", ifs.ev_cnt, 64'(nexp));
        chk("rnd_drop_cnt", ifs.drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ulpb_resp_agent.md
Name: ulpb_resp_agent

Overview:
- Parametrised N-channel host-side handshake engine for the ULPB node/controller layer interface.
- Per channel, it closes the four-phase handshakes RX_REQ/RX_ACK, RX_FAIL/RX_ACK and TX_SUCC|TX_FAIL/TX_RESP_ACK.
- Every completed event is serialised into one shared event log FIFO, with per-channel auto-ack enables and a selectable full-FIFO policy (stall or drop).
- Sits between NUM_CH bus layer interfaces and a single host/monitor consumer.

Parameters:
- NUM_CH, 4, number of layer channels served.
- ADDR_WIDTH, 8, RX address width per channel.
- DATA_WIDTH, 32, RX data width per channel.
- FIFO_DEPTH, 4, log FIFO entries; power of 2, ≥2.
- CNT_WIDTH, 16, width of saturating event and drop counters.
- DROP_ON_FULL, 0, 0 = stall acks while FIFO full; 1 = ack anyway and count the drop.

Ports:
- clk  in  1  clock.
- resetn  in  1  async active-low reset.
- auto_rx_en  in  NUM_CH  per-channel enable for acking RX_REQ; RX_FAIL is always acked.
- rx_req  in  NUM_CH  layer RX_REQ per channel.
- rx_fail  in  NUM_CH  layer RX_FAIL per channel.
- rx_addr  in  NUM_CH*ADDR_WIDTH  flattened RX_ADDR; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rx_data  in  NUM_CH*DATA_WIDTH  flattened RX_DATA, same packing.
- rx_ack  out  NUM_CH  RX_ACK per channel.
- tx_succ  in  NUM_CH  layer TX_SUCC.
- tx_fail  in  NUM_CH  layer TX_FAIL.
- tx_resp_ack  out  NUM_CH  TX_RESP_ACK per channel.
- log_valid  out  1  FIFO head valid.
- log_ready  in  1  consumer pop strobe.
- log_kind  out  2  head kind: 0 RX data, 1 RX fail, 2 TX success, 3 TX fail.
- log_ch  out  clog2(NUM_CH) (min 1)  head channel index.
- log_addr  out  ADDR_WIDTH  head address; 0 for kinds 1–3.
- log_data  out  DATA_WIDTH  head data; 0 for kinds 1–3.
- ev_cnt  out  CNT_WIDTH  saturating count of events enqueued.
- drop_cnt  out  CNT_WIDTH  saturating count of events dropped; always 0 when DROP_ON_FULL=0.

Behaviour:
- Reset: clk is the only clock, and resetn is asynchronous and active low. While resetn is low:
  - rx_ack, tx_resp_ack, log_valid, ev_cnt and drop_cnt are 0.
  - FIFO pointers are 0 and the round-robin pointer is 0.
  - All channel FSMs are in IDLE.
  - Reset mid-handshake drops every ack immediately. After release, any still-asserted request is handled as a new event.
- All inputs are synchronous to clk; synchronisation is the integrator's responsibility.
- Per-channel RX FSM states:
  - R_IDLE: the request source is rx_fail if high; otherwise rx_req & auto_rx_en. rx_fail takes precedence over rx_req in the same cycle (kind 1). On grant, go to R_ACK.
  - R_ACK: rx_ack=1 (registered, so it rises the cycle after the grant). Stay while rx_req|rx_fail. When both are low, go to R_IDLE and rx_ack falls the next cycle.
- Per-channel TX FSM, same structure:
  - T_IDLE: request when tx_succ|tx_fail. Kind is 2 if tx_succ, else 3; succ has precedence if both are high.
  - T_ACK: tx_resp_ack=1 until tx_succ and tx_fail are both low.
- Arbitration:
  - 2*NUM_CH requesters; index 2*ch for RX, 2*ch+1 for TX.
  - Round-robin: at most one grant per cycle. The pointer moves to granted index+1, wrapping at 2*NUM_CH.
- Grant condition:
  - DROP_ON_FULL=0: a grant is issued only when the FIFO is not full. The requester stays in IDLE with its ack low until granted.
  - DROP_ON_FULL=1: a grant is issued regardless. If the FIFO is full, nothing is written and drop_cnt increments; the ack still proceeds.
- Enqueue:
  - The granted event is written in the grant cycle with {kind, ch, addr, data} sampled that cycle.
  - ev_cnt increments on each write and saturates at all-ones.
- FIFO:
  - Show-ahead; the log_* fields reflect the head whenever log_valid=1.
  - A pop occurs when log_valid & log_ready.
  - Full is judged on registered state, so a same-cycle pop does not free space for that cycle's push.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers carry an extra wrap bit so that full and empty are distinguishable; occupancy spans 0..FIFO_DEPTH.
  - log_ready while empty has no effect.
- Minimum handshake: request seen in cycle t → ack high from t+1. Request dropped at t+k → ack low at t+k+1. The next event on the same source can be granted no earlier than t+k+1.

Test Plan:
- Single RX, ch1, auto_rx_en=4'b0010, addr 8'hab, data 32'hDEADBEEF, rx_req held until ack.
  - rx_ack[1] rises 1 cycle after rx_req.
  - Log head shows kind 0, ch 1, 8'hab, 32'hDEADBEEF; ev_cnt=1.
  - rx_ack[1] falls 1 cycle after rx_req drops.
- Auto-ack disabled, auto_rx_en=0, rx_req[2]=1 for 20 cycles → rx_ack[2] stays 0 and nothing is logged. Then assert rx_fail[2] → acked, and the log shows kind 1, ch 2.
- Simultaneous events: tx_succ[0], tx_fail[3], rx_req[1] all rise in the same cycle with pointer 0 → grants in order ch0-TX, ch1-RX, ch3-TX on 3 consecutive cycles. Log kinds are 2, 0, 3.
- Stall mode, FIFO_DEPTH=4, log_ready=0, five RX events on ch0:
  - Events 1–4 are acked and logged.
  - The 5th rx_ack stays 0 until one pop; the 5th event then enqueues the cycle after the pop.
  - drop_cnt stays 0.
- Drop mode, DROP_ON_FULL=1, same stimulus → all 5 are acked, drop_cnt=1, ev_cnt=4, and the FIFO holds the first 4 events.
- Reset mid-handshake: pulse resetn low while rx_ack[0]=1 → rx_ack=0 and log_valid=0 immediately, with both counters 0. With rx_req[0] still high after release, the event is re-acked and re-logged.
